// File: rtl/loader_pkg.sv
// ============================================================================
// Module : loader_pkg
// Brief  : Shared state encodings and helpers for the UART memory loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package loader_pkg;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_SETUP = 2'd1,
      WR_WRITE = 2'd2,
      WR_INC   = 2'd3
   } wr_state_t;

   // Counter width for a modulus n, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_os.sv
// ============================================================================
// Module : uart_rx_os
// Brief  : Oversampling 8N1 receiver with synchroniser and free-running tick.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_os
   import loader_pkg::*;
#(
   parameter int CLKS_PER_SAMPLE = 4,
   parameter int OVS             = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_error_pulse
);

   localparam int c_DIV_W = clog2_min1(CLKS_PER_SAMPLE);
   localparam int c_SUB_W = clog2_min1(OVS);
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLKS_PER_SAMPLE - 1);
   localparam logic [c_SUB_W-1:0] c_SUB_HALF = c_SUB_W'(OVS / 2 - 1);
   localparam logic [c_SUB_W-1:0] c_SUB_LAST = c_SUB_W'(OVS - 1);

   logic               r_rx_meta;
   logic               r_rx_sync;
   logic               r_rx_prev;
   logic [c_DIV_W-1:0] r_div;
   logic               w_tick;
   logic               w_fall;
   rx_state_t          r_state;
   rx_state_t          w_state_next;
   logic [c_SUB_W-1:0] r_sub;
   logic [c_SUB_W-1:0] w_sub_next;
   logic [2:0]         r_bit;
   logic [2:0]         w_bit_next;
   logic [7:0]         r_shift;
   logic [7:0]         w_shift_next;

   // Synchroniser and edge history idle high so reset release is not a start edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
         r_div     <= '0;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
         r_div     <= w_tick ? '0 : r_div + 1'b1;
      end
   end

   assign w_tick = (r_div == c_DIV_LAST);
   assign w_fall = r_rx_prev & ~r_rx_sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= RX_IDLE;
         r_sub   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_next;
         r_sub   <= w_sub_next;
         r_bit   <= w_bit_next;
         r_shift <= w_shift_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_sub_next        = r_sub;
      w_bit_next        = r_bit;
      w_shift_next      = r_shift;
      byte_valid        = 1'b0;
      frame_error_pulse = 1'b0;
      case (r_state)
         RX_IDLE: begin
            if (w_fall) begin
               w_state_next = RX_START;
               w_sub_next   = '0;
            end
         end
         RX_START: begin
            if (w_tick) begin
               if (r_sub == c_SUB_HALF) begin
                  w_sub_next   = '0;
                  w_bit_next   = '0;
                  w_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  w_sub_next = r_sub + 1'b1;
               end
            end
         end
         RX_DATA: begin
            if (w_tick) begin
               if (r_sub == c_SUB_LAST) begin
                  w_sub_next   = '0;
                  w_shift_next = {r_rx_sync, r_shift[7:1]};
                  w_bit_next   = r_bit + 1'b1;
                  if (r_bit == 3'd7) begin
                     w_state_next = RX_STOP;
                  end
               end else begin
                  w_sub_next = r_sub + 1'b1;
               end
            end
         end
         RX_STOP: begin
            if (w_tick) begin
               if (r_sub == c_SUB_LAST) begin
                  byte_valid        = r_rx_sync;
                  frame_error_pulse = ~r_rx_sync;
                  w_sub_next        = '0;
                  w_state_next      = RX_IDLE;
               end else begin
                  w_sub_next = r_sub + 1'b1;
               end
            end
         end
         default: w_state_next = RX_IDLE;
      endcase
   end

   assign rx_byte = r_shift;

endmodule

`default_nettype wire

// File: rtl/uart_mem_loader.sv
// ============================================================================
// Module : uart_mem_loader
// Brief  : Assembles UART bytes into little-endian words and writes them out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_mem_loader
   import loader_pkg::*;
#(
   parameter int          ADR_W           = 21,
   parameter int          WORD_BYTES      = 1,
   parameter int          CLKS_PER_SAMPLE = 4,
   parameter int          OVS             = 12,
   parameter int unsigned BASE_ADR        = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    rx,
   output logic [ADR_W-1:0]        adr,
   output logic [WORD_BYTES*8-1:0] data,
   output logic                    write,
   input  logic                    write_ready,
   output logic                    busy,
   output logic                    frame_err,
   output logic                    overrun,
   output logic [ADR_W-1:0]        word_count
);

   localparam int                 c_IDX_W    = clog2_min1(WORD_BYTES);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WORD_BYTES - 1);
   localparam logic [ADR_W-1:0]   c_BASE     = ADR_W'(BASE_ADR);

   logic [7:0]                  w_rx_byte;
   logic                        w_byte_valid;
   logic                        w_frame_error_pulse;
   logic [c_IDX_W-1:0]          r_idx;
   logic [WORD_BYTES-1:0][7:0]  r_lanes;
   logic [WORD_BYTES*8-1:0]     w_word;
   logic                        w_word_done;
   logic                        w_accept;
   wr_state_t                   r_wr_state;
   wr_state_t                   w_wr_next;

   uart_rx_os #(
      .CLKS_PER_SAMPLE (CLKS_PER_SAMPLE),
      .OVS             (OVS)
   ) u_rx (
      .clk               (clk),
      .reset             (reset),
      .rx                (rx),
      .rx_byte           (w_rx_byte),
      .byte_valid        (w_byte_valid),
      .frame_error_pulse (w_frame_error_pulse)
   );

   assign w_word_done = w_byte_valid && (r_idx == c_IDX_LAST);
   assign w_accept    = w_word_done && (r_wr_state == WR_IDLE);

   // The completing byte is merged directly so the word is ready in the byte_valid cycle.
   for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign w_word[gi*8 +: 8] = (r_idx == c_IDX_W'(gi)) ? w_rx_byte : r_lanes[gi];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_state <= WR_IDLE;
      end else begin
         r_wr_state <= w_wr_next;
      end
   end

   always_comb begin
      w_wr_next = r_wr_state;
      write     = 1'b0;
      case (r_wr_state)
         WR_IDLE:  if (w_word_done) w_wr_next = WR_SETUP;
         WR_SETUP: w_wr_next = WR_WRITE;
         WR_WRITE: begin
            write = 1'b1;
            if (write_ready) w_wr_next = WR_INC;
         end
         WR_INC:   w_wr_next = WR_IDLE;
         default:  w_wr_next = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx      <= '0;
         r_lanes    <= '0;
         data       <= '0;
         adr        <= c_BASE;
         word_count <= '0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (w_byte_valid) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
               if (r_idx == c_IDX_W'(i)) r_lanes[i] <= w_rx_byte;
            end
            r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
         end
         if (w_accept) data <= w_word;
         // A word finishing during WR_INC is counted as overrun: conservative by design.
         if (w_word_done && (r_wr_state != WR_IDLE)) overrun <= 1'b1;
         if (w_frame_error_pulse) frame_err <= 1'b1;
         if (r_wr_state == WR_INC) begin
            adr        <= adr + 1'b1;
            word_count <= word_count + 1'b1;
         end
      end
   end

   assign busy = (r_idx != '0) || (r_wr_state != WR_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
// ============================================================================
// Module : tb_uart_mem_loader
// Brief  : Randomised self-checking bench for two loader configurations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_mem_loader;

   localparam int BIT_CLKS = 48;

   typedef struct {
      logic [31:0] adr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        rx_a, rx_b;
   logic        rdy_fix_a, rdy_rnd_a, rnd_mode_a, rdy_a, rdy_b;
   logic [20:0] adr_a, wc_a;
   logic [7:0]  data_a;
   logic        write_a, busy_a, fe_a, ov_a;
   logic [3:0]  adr_b, wc_b;
   logic [15:0] data_b;
   logic        write_b, busy_b, fe_b, ov_b;

   assign rdy_a = rnd_mode_a ? rdy_rnd_a : rdy_fix_a;

   uart_mem_loader dut_a (
      .clk (clk), .reset (reset), .rx (rx_a), .adr (adr_a), .data (data_a),
      .write (write_a), .write_ready (rdy_a), .busy (busy_a),
      .frame_err (fe_a), .overrun (ov_a), .word_count (wc_a)
   );

   uart_mem_loader #(.ADR_W (4), .WORD_BYTES (2), .BASE_ADR (15)) dut_b (
      .clk (clk), .reset (reset), .rx (rx_b), .adr (adr_b), .data (data_b),
      .write (write_b), .write_ready (rdy_b), .busy (busy_b),
      .frame_err (fe_b), .overrun (ov_b), .word_count (wc_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: expected write sequence and flag state per instance.
   logic [31:0] m_adr_a, m_cnt_a, m_adr_b, m_cnt_b;
   logic        m_fe_a, m_ov_a, m_fe_b;
   logic [7:0]  m_lane_b[$];
   wr_t         exp_a[$];
   wr_t         exp_b[$];

   task automatic model_reset();
      m_adr_a = 0; m_cnt_a = 0; m_fe_a = 0; m_ov_a = 0; exp_a.delete();
      m_adr_b = 15; m_cnt_b = 0; m_fe_b = 0; m_lane_b.delete(); exp_b.delete();
   endtask

   task automatic model_a(input logic [7:0] b, input bit stop_ok, input bit pending);
      if (!stop_ok) m_fe_a = 1;
      else if (pending) m_ov_a = 1;
      else begin
         exp_a.push_back('{m_adr_a, {24'b0, b}});
         m_adr_a = (m_adr_a + 1) % (1 << 21);
         m_cnt_a = (m_cnt_a + 1) % (1 << 21);
      end
   endtask

   task automatic model_b(input logic [7:0] b, input bit stop_ok);
      if (!stop_ok) m_fe_b = 1;
      else begin
         m_lane_b.push_back(b);
         if (m_lane_b.size() == 2) begin
            exp_b.push_back('{m_adr_b, {16'b0, m_lane_b[1], m_lane_b[0]}});
            m_lane_b.delete();
            m_adr_b = (m_adr_b + 1) % 16;
            m_cnt_b = (m_cnt_b + 1) % 16;
         end
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input bit to_b, input logic [7:0] b, input bit stop_ok);
      logic [9:0] frame;
      frame = {stop_ok, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (to_b) rx_b = frame[i]; else rx_a = frame[i];
         wait_clks(BIT_CLKS);
      end
      if (to_b) rx_b = 1'b1; else rx_a = 1'b1;
      wait_clks($urandom_range(4, 30));
   endtask

   task automatic check_reset_values();
      check("a_rst_adr", adr_a, 0);  check("a_rst_data", data_a, 0);
      check("a_rst_write", write_a, 0); check("a_rst_busy", busy_a, 0);
      check("a_rst_fe", fe_a, 0);    check("a_rst_ov", ov_a, 0);
      check("a_rst_wc", wc_a, 0);
      check("b_rst_adr", adr_b, 15); check("b_rst_data", data_b, 0);
      check("b_rst_write", write_b, 0); check("b_rst_busy", busy_b, 0);
      check("b_rst_fe", fe_b, 0);    check("b_rst_ov", ov_b, 0);
      check("b_rst_wc", wc_b, 0);
   endtask

   task automatic check_final_a();
      check("a_adr", adr_a, m_adr_a);
      check("a_wc", wc_a, m_cnt_a);
      check("a_fe", fe_a, m_fe_a);
      check("a_ov", ov_a, m_ov_a);
      check("a_pending", exp_a.size(), 0);
   endtask

   task automatic check_final_b();
      check("b_adr", adr_b, m_adr_b);
      check("b_wc", wc_b, m_cnt_b);
      check("b_fe", fe_b, m_fe_b);
      check("b_pending", exp_b.size(), 0);
   endtask

   initial begin
      rdy_rnd_a = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         rdy_rnd_a = 1'($urandom_range(0, 1));
      end
   end

   int since_a = 1000;
   bit prev_wr_a = 1'b0;

   always @(negedge clk) begin
      if (dut_a.w_byte_valid) since_a = 0;
      else if (since_a < 1000) since_a++;
      if (write_a && !prev_wr_a) check("a_wr_latency", since_a, 2);
      prev_wr_a = write_a;
      if (write_a) begin
         check("a_busy_wr", busy_a, 1);
         if (exp_a.size() == 0) check("a_wr_spurious", write_a, 0);
         else begin
            check("a_wr_adr", adr_a, exp_a[0].adr);
            check("a_wr_data", data_a, exp_a[0].data);
            if (rdy_a) void'(exp_a.pop_front());
         end
      end
      if (write_b) begin
         if (exp_b.size() == 0) check("b_wr_spurious", write_b, 0);
         else begin
            check("b_wr_adr", adr_b, exp_b[0].adr);
            check("b_wr_data", data_b, exp_b[0].data);
            if (rdy_b) void'(exp_b.pop_front());
         end
      end
   end

   initial begin
      logic [7:0] b;
      reset = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
      rdy_fix_a = 1'b1; rnd_mode_a = 1'b0; rdy_b = 1'b1;
      model_reset();
      #2 reset = 1'b0;
      #20;
      check_reset_values();
      #13 reset = 1'b1;
      wait_clks(10);

      // Instance A: two directed bytes with ready tied high.
      model_a(8'hA5, 1, 0); send(0, 8'hA5, 1);
      model_a(8'h3C, 1, 0); send(0, 8'h3C, 1);
      wait_clks(10);
      check_final_a();

      // Short low glitch must not start a byte.
      rx_a = 1'b0; wait_clks(20); rx_a = 1'b1;
      wait_clks(200);
      check("a_glitch_busy", busy_a, 0);
      check_final_a();

      // Random bytes with a randomly stalling write_ready.
      rnd_mode_a = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         model_a(b, 1, 0); send(0, b, 1);
      end
      wait_clks(20);
      rnd_mode_a = 1'b0;
      wait_clks(5);
      check_final_a();

      // Bad stop bit discards the byte; the next byte goes to the next address.
      model_a(8'h55, 0, 0); send(0, 8'h55, 0);
      check("a_fe_set", fe_a, 1);
      model_a(8'h66, 1, 0); send(0, 8'h66, 1);
      wait_clks(10);
      check_final_a();

      // Stalled write while a second word completes.
      rdy_fix_a = 1'b0;
      b = 8'($urandom);
      model_a(b, 1, 0); send(0, b, 1);
      b = 8'($urandom);
      model_a(b, 1, 1); send(0, b, 1);
      check("a_ov_set", ov_a, 1);
      check("a_stall_write", write_a, 1);
      check("a_stall_adr", adr_a, (m_adr_a - 1) % (1 << 21));
      rdy_fix_a = 1'b1;
      wait_clks(10);
      check_final_a();

      // Instance B: 16-bit words, frame error mid-word, address wrap.
      model_b(8'h34, 1); send(1, 8'h34, 1);
      check("b_busy_mid", busy_b, 1);
      model_b(8'h99, 0); send(1, 8'h99, 0);
      check("b_busy_after_fe", busy_b, 1);
      model_b(8'h12, 1); send(1, 8'h12, 1);
      model_b(8'h78, 1); send(1, 8'h78, 1);
      model_b(8'h56, 1); send(1, 8'h56, 1);
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         model_b(b, 1); send(1, b, 1);
      end
      wait_clks(10);
      check("b_busy_idle", busy_b, 0);
      check_final_b();

      // Reset in the middle of a data bit, checked before the next clock edge.
      rx_b = 1'b0;
      wait_clks(3 * BIT_CLKS + BIT_CLKS / 2);
      #2 reset = 1'b0; rx_b = 1'b1;
      model_reset();
      #1;
      check_reset_values();
      wait_clks(5);
      #3 reset = 1'b1;
      wait_clks(3 * BIT_CLKS);
      check("b_post_rst_busy", busy_b, 0);
      check("b_post_rst_adr", adr_b, 15);
      model_b(8'hC3, 1); send(1, 8'hC3, 1);
      model_b(8'h5A, 1); send(1, 8'h5A, 1);
      wait_clks(10);
      check_final_b();
      check_final_a();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
